// File: rtl/alu_pkg.sv
// ALU arbiter shared definitions.
// Op-bit indices, datapath widths, op check.
package alu_pkg;

  localparam int XLEN = 32;
  localparam int OP_W = 12;

  localparam int OP_ADD  = 0;
  localparam int OP_SUB  = 1;
  localparam int OP_SLT  = 2;
  localparam int OP_SLTU = 3;
  localparam int OP_AND  = 4;
  localparam int OP_NOR  = 5;
  localparam int OP_OR   = 6;
  localparam int OP_XOR  = 7;
  localparam int OP_SLL  = 8;
  localparam int OP_SRL  = 9;
  localparam int OP_SRA  = 10;
  localparam int OP_LUI  = 11;

  function automatic logic is_onehot(
    input logic [OP_W-1:0] v
  );
    return $onehot(v);
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bus of the ALU arbiter.
// slave = arbiter side, master = user side.
interface alu_arbiter_if;
  import alu_pkg::*;

  logic            req0_valid;
  logic            req0_ready;
  logic [OP_W-1:0] req0_op;
  logic [XLEN-1:0] req0_src1;
  logic [XLEN-1:0] req0_src2;

  logic            req1_valid;
  logic            req1_ready;
  logic [OP_W-1:0] req1_op;
  logic [XLEN-1:0] req1_src1;
  logic [XLEN-1:0] req1_src2;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_result;
  logic            rsp_port;
  logic            rsp_err;

  logic [15:0]     grant_cnt0;
  logic [15:0]     grant_cnt1;

  modport slave (
    input  req0_valid, req0_op,
    input  req0_src1, req0_src2,
    output req0_ready,
    input  req1_valid, req1_op,
    input  req1_src1, req1_src2,
    output req1_ready,
    output rsp_valid, rsp_result,
    output rsp_port, rsp_err,
    input  rsp_ready,
    output grant_cnt0, grant_cnt1
  );

  modport master (
    output req0_valid, req0_op,
    output req0_src1, req0_src2,
    input  req0_ready,
    output req1_valid, req1_op,
    output req1_src1, req1_src2,
    input  req1_ready,
    input  rsp_valid, rsp_result,
    input  rsp_port, rsp_err,
    output rsp_ready,
    input  grant_cnt0, grant_cnt1
  );

endinterface

// File: rtl/alu.sv
// Combinational one-hot controlled ALU.
// Non one-hot control yields zero.
module alu
  import alu_pkg::*;
(
  input  logic [OP_W-1:0] alu_control,
  input  logic [XLEN-1:0] alu_src1,
  input  logic [XLEN-1:0] alu_src2,
  output logic [XLEN-1:0] alu_result
);

  logic [4:0] shamt;
  logic       lt_s;
  logic       lt_u;

  assign shamt = alu_src1[4:0];
  assign lt_s  = $signed(alu_src1) < $signed(alu_src2);
  assign lt_u  = alu_src1 < alu_src2;

  // Select the operation named by the control bit
  always_comb begin
    alu_result = '0;
    if (is_onehot(alu_control)) begin
      unique case (1'b1)
        alu_control[OP_ADD]:
          alu_result = alu_src1 + alu_src2;
        alu_control[OP_SUB]:
          alu_result = alu_src1 - alu_src2;
        alu_control[OP_SLT]:
          alu_result = {{(XLEN-1){1'b0}}, lt_s};
        alu_control[OP_SLTU]:
          alu_result = {{(XLEN-1){1'b0}}, lt_u};
        alu_control[OP_AND]:
          alu_result = alu_src1 & alu_src2;
        alu_control[OP_NOR]:
          alu_result = ~(alu_src1 | alu_src2);
        alu_control[OP_OR]:
          alu_result = alu_src1 | alu_src2;
        alu_control[OP_XOR]:
          alu_result = alu_src1 ^ alu_src2;
        alu_control[OP_SLL]:
          alu_result = alu_src2 << shamt;
        alu_control[OP_SRL]:
          alu_result = alu_src2 >> shamt;
        alu_control[OP_SRA]:
          alu_result = $unsigned(
            $signed(alu_src2) >>> shamt);
        alu_control[OP_LUI]:
          alu_result = {alu_src2[15:0], 16'h0};
        default:
          alu_result = '0;
      endcase
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-port round-robin front end for one ALU.
// One-entry registered response, full rate.
module alu_arbiter
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  alu_arbiter_if.slave  bus
);

  logic            win;
  logic            accept_ok;
  logic            accept;
  logic [OP_W-1:0] alu_ctl;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] alu_res;

  logic            rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0] rsp_result_q, rsp_result_d;
  logic            rsp_port_q, rsp_port_d;
  logic            rsp_err_q, rsp_err_d;
  logic            prio_q, prio_d;
  logic [15:0]     cnt0_q, cnt0_d;
  logic [15:0]     cnt1_q, cnt1_d;

  // Pick winner and decide whether to accept
  always_comb begin
    win = bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) begin
      win = prio_q;
    end
    accept_ok = ~rsp_valid_q | bus.rsp_ready;
    accept = ~reset & accept_ok &
             (bus.req0_valid | bus.req1_valid);
  end

  // win=1 implies req1 valid, win=0 with accept implies req0
  assign bus.req0_ready = accept & ~win;
  assign bus.req1_ready = accept & win;

  assign alu_ctl = win ? bus.req1_op   : bus.req0_op;
  assign alu_a   = win ? bus.req1_src1 : bus.req0_src1;
  assign alu_b   = win ? bus.req1_src2 : bus.req0_src2;

  alu u_alu (
    .alu_control (alu_ctl),
    .alu_src1    (alu_a),
    .alu_src2    (alu_b),
    .alu_result  (alu_res)
  );

  // Load, hold or drain the response; advance prio
  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_port_d   = rsp_port_q;
    rsp_err_d    = rsp_err_q;
    prio_d       = prio_q;
    cnt0_d       = cnt0_q;
    cnt1_d       = cnt1_q;
    if (accept) begin
      rsp_valid_d  = 1'b1;
      rsp_result_d = alu_res;
      rsp_port_d   = win;
      rsp_err_d    = ~is_onehot(alu_ctl);
      prio_d       = ~win;
      if (win) begin
        cnt1_d = cnt1_q + 16'd1;
      end else begin
        cnt0_d = cnt0_q + 16'd1;
      end
    end else if (bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_port_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
      prio_q       <= 1'b0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_port_q   <= rsp_port_d;
      rsp_err_q    <= rsp_err_d;
      prio_q       <= prio_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_port   = rsp_port_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.grant_cnt0 = cnt0_q;
  assign bus.grant_cnt1 = cnt1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter.
// Directed cases plus random traffic vs model.
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  alu_arbiter_if bus();

  alu_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // reference state: what the outside world should see
  logic        m_valid;
  logic [31:0] m_res;
  logic        m_port;
  logic        m_err;
  logic        m_prio;
  logic [15:0] m_cnt0;
  logic [15:0] m_cnt1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  function automatic int ones(input logic [11:0] op);
    int n = 0;
    for (int i = 0; i < 12; i++) n += int'(op[i]);
    return n;
  endfunction

  function automatic logic [31:0] ref_alu(
    input logic [11:0] op,
    input logic [31:0] a,
    input logic [31:0] b);
    int k = 0;
    int sh;
    if (ones(op) != 1) return 32'd0;
    for (int i = 0; i < 12; i++) if (op[i]) k = i;
    sh = int'(a[4:0]);
    case (k)
      0: return a + b;
      1: return a - b;
      2: return ($signed(a) < $signed(b)) ? 1 : 0;
      3: return (a < b) ? 1 : 0;
      4: return a & b;
      5: return ~(a | b);
      6: return a | b;
      7: return a ^ b;
      8: return b << sh;
      9: return b >> sh;
      10: return $unsigned($signed(b) >>> sh);
      default: return {b[15:0], 16'h0000};
    endcase
  endfunction

  task automatic drive(
    input logic rst, v0, v1,
    input logic [11:0] o0, o1,
    input logic [31:0] a0, b0, a1, b1,
    input logic rr);
    logic ok, w;
    @(negedge clk);
    chk("rsp_valid", bus.rsp_valid, m_valid);
    chk("cnt0", bus.grant_cnt0, m_cnt0);
    chk("cnt1", bus.grant_cnt1, m_cnt1);
    if (m_valid) begin
      chk("rsp_result", bus.rsp_result, m_res);
      chk("rsp_port", bus.rsp_port, m_port);
      chk("rsp_err", bus.rsp_err, m_err);
    end
    reset = rst;
    bus.req0_valid = v0; bus.req1_valid = v1;
    bus.req0_op = o0;    bus.req1_op = o1;
    bus.req0_src1 = a0;  bus.req0_src2 = b0;
    bus.req1_src1 = a1;  bus.req1_src2 = b1;
    bus.rsp_ready = rr;
    #1;
    ok = !rst && (!m_valid || rr);
    w = (v0 && v1) ? m_prio : v1;
    chk("ready0", bus.req0_ready, ok && v0 && !w);
    chk("ready1", bus.req1_ready, ok && v1 && w);
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_res = 0; m_port = 0; m_err = 0;
      m_prio = 0; m_cnt0 = 0; m_cnt1 = 0;
    end else if (ok && (v0 || v1)) begin
      m_valid = 1;
      m_port = w;
      m_res = w ? ref_alu(o1, a1, b1)
                : ref_alu(o0, a0, b0);
      m_err = (ones(w ? o1 : o0) != 1);
      m_prio = !w;
      if (w) m_cnt1++;
      else m_cnt0++;
    end else if (rr) begin
      m_valid = 0;
    end
  endtask

  // port-0-only op with consumer ready
  task automatic p0(input logic [11:0] op,
                    input logic [31:0] a,
                    input logic [31:0] b);
    drive(0, 1, 0, op, 0, a, b, 0, 0, 1);
  endtask

  localparam logic [31:0] K = 32'h0000_1111;
  logic [31:0] hold;
  logic        last_port;
  logic [11:0] r0, r1;

  initial begin
    bus.req0_valid = 0; bus.req1_valid = 0;
    bus.req0_op = 0;    bus.req1_op = 0;
    bus.req0_src1 = 0;  bus.req0_src2 = 0;
    bus.req1_src1 = 0;  bus.req1_src2 = 0;
    bus.rsp_ready = 0;
    reset = 1;
    repeat (2) @(posedge clk);
    m_valid = 0; m_res = 0; m_port = 0; m_err = 0;
    m_prio = 0; m_cnt0 = 0; m_cnt1 = 0;
    #1;
    chk("rst_valid", bus.rsp_valid, 0);
    chk("rst_result", bus.rsp_result, 0);
    chk("rst_port", bus.rsp_port, 0);
    chk("rst_err", bus.rsp_err, 0);
    chk("rst_cnt0", bus.grant_cnt0, 0);
    chk("rst_cnt1", bus.grant_cnt1, 0);
    chk("rst_rdy0", bus.req0_ready, 0);

    // single add on port 0
    p0(12'h001, K, K);
    #1;
    chk("add_res", bus.rsp_result, 32'h2222);
    chk("add_port", bus.rsp_port, 0);
    chk("add_cnt0", bus.grant_cnt0, 1);

    // alternating grants from a fresh reset
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 1, 12'h002, 12'h002,
            K, K, K, K, 1);
      #1;
      chk("rr_port", bus.rsp_port, i % 2);
      chk("rr_res", bus.rsp_result, 0);
      chk("rr_valid", bus.rsp_valid, 1);
    end

    p0(12'h004, 32'hFFFF_FFFF, 1);
    #1 chk("slt", bus.rsp_result, 1);
    p0(12'h008, 32'hFFFF_FFFF, 1);
    #1 chk("sltu", bus.rsp_result, 0);
    p0(12'h100, 4, K);
    #1 chk("sll", bus.rsp_result, 32'h0001_1110);
    p0(12'h800, 0, K);
    #1 chk("lui", bus.rsp_result, 32'h1111_0000);

    // bad one-hot codes
    p0(12'h003, K, K);
    #1;
    chk("err3_e", bus.rsp_err, 1);
    chk("err3_r", bus.rsp_result, 0);
    p0(12'h000, K, K);
    #1;
    chk("err0_e", bus.rsp_err, 1);
    chk("err0_r", bus.rsp_result, 0);

    // back-pressure with both requesters waiting
    drive(0, 1, 1, 12'h001, 12'h080,
          1, 2, 32'hF0, 32'h0F, 1);
    #1;
    hold = bus.rsp_result;
    chk("bp_first", hold, m_res);
    last_port = m_port;
    repeat (3) begin
      drive(0, 1, 1, 12'h001, 12'h080,
            5, 6, 7, 8, 0);
      #1;
      chk("bp_hold", bus.rsp_result, hold);
      chk("bp_port", bus.rsp_port, last_port);
    end
    drive(0, 1, 1, 12'h001, 12'h080,
          5, 6, 7, 8, 1);
    #1 chk("bp_resume", bus.rsp_port, !last_port);

    // reset while a result is pending
    drive(0, 0, 1, 0, 12'h001, 0, 0, 3, 4, 0);
    drive(1, 1, 1, 12'h001, 12'h001,
          1, 1, 1, 1, 0);
    #1;
    chk("rstp_valid", bus.rsp_valid, 0);
    chk("rstp_cnt0", bus.grant_cnt0, 0);
    chk("rstp_cnt1", bus.grant_cnt1, 0);
    drive(0, 1, 1, 12'h001, 12'h001,
          1, 1, 1, 1, 1);
    #1 chk("rstp_first", bus.rsp_port, 0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      r0 = 12'(1 << $urandom_range(0, 11));
      r1 = 12'(1 << $urandom_range(0, 11));
      if ($urandom_range(0, 9) == 0) r0 = 12'($urandom);
      if ($urandom_range(0, 9) == 0) r1 = 12'($urandom);
      drive($urandom_range(0, 49) == 0,
            1'($urandom), 1'($urandom), r0, r1,
            $urandom, $urandom, $urandom, $urandom,
            $urandom_range(0, 3) != 0);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
